// File: rtl/sbox_perm_builder_pkg.sv
// Shared definitions for the substitution-table builder: state encoding, default symbol
// width and lookup-mode encodings.
package sbox_perm_builder_pkg;

   localparam int unsigned DataWDefault = 8;

   // Lookup direction on sub_mode.
   localparam logic SubFwd = 1'b0;
   localparam logic SubInv = 1'b1;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StFill  = 2'd1,
      StReady = 2'd2
   } state_e;

endpackage

// File: rtl/sbox_perm_builder_if.sv
// Candidate stream, build status and lookup port of the substitution-table builder.
interface sbox_perm_builder_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned REJ_W  = 16
);

   logic              start;
   logic              cand_valid;
   logic [DATA_W-1:0] cand_data;
   logic              cand_ready;
   logic              load_done;
   logic              table_ready;
   logic [REJ_W-1:0]  rej_count;
   logic              sub_valid;
   logic              sub_mode;
   logic [DATA_W-1:0] sub_data;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;

   // Key generator / cipher side.
   modport master (
      output start, cand_valid, cand_data, sub_valid, sub_mode, sub_data,
      input  cand_ready, load_done, table_ready, rej_count, out_valid, out_data
   );

   // Table builder side.
   modport slave (
      input  start, cand_valid, cand_data, sub_valid, sub_mode, sub_data,
      output cand_ready, load_done, table_ready, rej_count, out_valid, out_data
   );

endinterface

// File: rtl/sbox_perm_builder_ram.sv
// DEPTH x DATA_W table storage: one write port, one registered read port.
module sbox_perm_builder_ram #(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [DATA_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [DATA_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int unsigned DEPTH = 1 << DATA_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // Write port; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Registered read; holds the last result between reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/sbox_perm_builder.sv
// Builds a bijective substitution table from a candidate stream, rejecting duplicates,
// then serves forward (and optionally inverse) lookups with one-cycle latency.
module sbox_perm_builder
   import sbox_perm_builder_pkg::*;
#(
   parameter int unsigned DATA_W = DataWDefault,
   parameter int unsigned INV_EN = 1,
   parameter int unsigned REJ_W  = 16
) (
   input logic                clk,
   input logic                rst_n,
   sbox_perm_builder_if.slave bus
);

   localparam int unsigned DEPTH = 1 << DATA_W;
   // Index of the last table slot; idx is one bit wider so it never wraps.
   localparam logic [DATA_W:0] IdxLast = (DATA_W + 1)'(DEPTH - 1);

   state_e              state_q, state_d;
   logic [DATA_W:0]     idx_q;
   logic [REJ_W-1:0]    rej_q;
   logic [DEPTH-1:0]    used_q;
   logic                load_done_q;
   logic                out_valid_q;
   logic                mode_q;

   logic                accept;
   logic                wr_en;
   logic                fill_last;
   logic                lookup;
   logic [DATA_W-1:0]   fwd_rd;
   logic [DATA_W-1:0]   inv_rd;

   // start in the same cycle drops the candidate.
   assign accept    = (state_q == StFill) & bus.cand_valid & ~bus.start;
   assign wr_en     = accept & ~used_q[bus.cand_data];
   assign fill_last = wr_en & (idx_q == IdxLast);
   assign lookup    = (state_q == StReady) & bus.sub_valid;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: start restarts from anywhere; last unique accept completes the table.
   always_comb begin
      state_d = state_q;
      if (bus.start) begin
         state_d = StFill;
      end else if (fill_last) begin
         state_d = StReady;
      end
   end

   // Outputs decoded from state and status registers.
   always_comb begin
      bus.cand_ready  = (state_q == StFill);
      bus.table_ready = (state_q == StReady);
      bus.load_done   = load_done_q;
      bus.rej_count   = rej_q;
      bus.out_valid   = out_valid_q;
      bus.out_data    = (INV_EN != 0 && mode_q == SubInv) ? inv_rd : fwd_rd;
   end

   // Build bookkeeping: used bitmap, fill index, saturating reject counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q       <= '0;
         rej_q       <= '0;
         used_q      <= '0;
         load_done_q <= 1'b0;
      end else begin
         load_done_q <= fill_last;
         if (bus.start) begin
            idx_q  <= '0;
            rej_q  <= '0;
            used_q <= '0;
         end else if (wr_en) begin
            used_q[bus.cand_data] <= 1'b1;
            idx_q                 <= idx_q + {{DATA_W{1'b0}}, 1'b1};
         end else if (accept && rej_q != '1) begin
            rej_q <= rej_q + {{(REJ_W - 1){1'b0}}, 1'b1};
         end
      end
   end

   // Lookup pipeline: valid and direction travel alongside the RAM read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         mode_q      <= SubFwd;
      end else begin
         out_valid_q <= lookup;
         if (lookup) begin
            mode_q <= bus.sub_mode;
         end
      end
   end

   sbox_perm_builder_ram #(
      .DATA_W (DATA_W)
   ) u_fwd_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_en),
      .waddr (idx_q[DATA_W-1:0]),
      .wdata (bus.cand_data),
      .re    (lookup),
      .raddr (bus.sub_data),
      .rdata (fwd_rd)
   );

   if (INV_EN != 0) begin : g_inv
      sbox_perm_builder_ram #(
         .DATA_W (DATA_W)
      ) u_inv_ram (
         .clk   (clk),
         .rst_n (rst_n),
         .we    (wr_en),
         .waddr (bus.cand_data),
         .wdata (idx_q[DATA_W-1:0]),
         .re    (lookup),
         .raddr (bus.sub_data),
         .rdata (inv_rd)
      );
   end else begin : g_no_inv
      assign inv_rd = '0;
   end

endmodule

// File: tb/tb_sbox_perm_builder.sv
// Scoreboard bench for sbox_perm_builder: random candidate streams against a set/list model.
module tb_sbox_perm_builder;
   import sbox_perm_builder_pkg::*;

   localparam int unsigned DW = 8;
   localparam int unsigned RW = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sbox_perm_builder_if #(.DATA_W(DW), .REJ_W(RW)) bus ();

   sbox_perm_builder #(
      .DATA_W (DW),
      .INV_EN (1),
      .REJ_W  (RW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      string      name;
      logic [7:0] val;
   } exp_t;

   int n_checks = 0;
   int n_pass = 0;
   exp_t sb[$];

   // Model: the table is the distinct candidates in order of first arrival.
   logic [7:0] order[$];
   bit         seen[256];
   int         fed;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endfunction

   function automatic void model_reset();
      order.delete();
      foreach (seen[i]) seen[i] = 1'b0;
      fed = 0;
   endfunction

   function automatic int model_rej();
      int r;
      r = fed - order.size();
      return (r > 65535) ? 65535 : r;
   endfunction

   function automatic logic [7:0] model_fwd(int x);
      return order[x];
   endfunction

   function automatic logic [7:0] model_inv(logic [7:0] y);
      foreach (order[i]) if (order[i] == y) return 8'(i);
      return 8'h00;
   endfunction

   // Monitor: every presented result must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid) begin
         exp_t e;
         if (sb.size() == 0) begin
            check("unexpected_out_valid", {31'd0, bus.out_valid}, 32'd0);
         end else begin
            e = sb.pop_front();
            check(e.name, {24'd0, bus.out_data}, {24'd0, e.val});
         end
      end
   end

   task automatic do_start();
      @(posedge clk); #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      model_reset();
   endtask

   task automatic feed(input logic [7:0] c);
      int gap;
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      repeat (gap) begin
         @(posedge clk); #1 bus.cand_valid = 1'b0;
      end
      @(posedge clk); #1;
      bus.cand_valid = 1'b1;
      bus.cand_data  = c;
      fed++;
      if (!seen[c]) begin
         seen[c] = 1'b1;
         order.push_back(c);
      end
   endtask

   task automatic finish_build(input string tag);
      @(posedge clk); #1 bus.cand_valid = 1'b0;
      @(negedge clk);
      check({tag, "_load_done_pulse"}, {31'd0, bus.load_done}, 32'd1);
      check({tag, "_table_ready"}, {31'd0, bus.table_ready}, 32'd1);
      check({tag, "_cand_ready_low"}, {31'd0, bus.cand_ready}, 32'd0);
      check({tag, "_rej_count"}, {16'd0, bus.rej_count}, model_rej());
      @(negedge clk);
      check({tag, "_load_done_end"}, {31'd0, bus.load_done}, 32'd0);
      check({tag, "_table_ready_hold"}, {31'd0, bus.table_ready}, 32'd1);
   endtask

   task automatic lookup(input logic mode, input logic [7:0] addr, input logic [7:0] exp,
                         input string name);
      exp_t e;
      @(posedge clk); #1;
      bus.sub_valid = 1'b1;
      bus.sub_mode  = mode;
      bus.sub_data  = addr;
      e.name = name;
      e.val  = exp;
      sb.push_back(e);
   endtask

   task automatic lookup_end();
      @(posedge clk); #1 bus.sub_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("scoreboard_drained", sb.size(), 32'd0);
   endtask

   task automatic random_lookups(input int n, input string tag);
      logic [7:0] a;
      for (int k = 0; k < n; k++) begin
         a = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 1) == 0) lookup(SubFwd, a, model_fwd(int'(a)), {tag, "_rnd_fwd"});
         else lookup(SubInv, a, model_inv(a), {tag, "_rnd_inv"});
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cand_ready"}, {31'd0, bus.cand_ready}, 32'd0);
      check({tag, "_load_done"}, {31'd0, bus.load_done}, 32'd0);
      check({tag, "_table_ready"}, {31'd0, bus.table_ready}, 32'd0);
      check({tag, "_rej_count"}, {16'd0, bus.rej_count}, 32'd0);
      check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
      check({tag, "_out_data"}, {24'd0, bus.out_data}, 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.start      = 1'b0;
      bus.cand_valid = 1'b0;
      bus.cand_data  = '0;
      bus.sub_valid  = 1'b0;
      bus.sub_mode   = 1'b0;
      bus.sub_data   = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // 1: idle after reset; lookups and candidates are ignored.
      repeat (10) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("t1");
      @(posedge clk); #1;
      bus.sub_valid  = 1'b1;
      bus.sub_data   = 8'h33;
      bus.cand_valid = 1'b1;
      @(posedge clk); #1;
      bus.sub_valid  = 1'b0;
      bus.cand_valid = 1'b0;
      @(negedge clk);
      check("t1_idle_lookup_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("t1_idle_cand_ready", {31'd0, bus.cand_ready}, 32'd0);

      // 2: ascending identity build.
      do_start();
      @(negedge clk);
      check("t2_cand_ready_fill", {31'd0, bus.cand_ready}, 32'd1);
      for (int i = 0; i < 256; i++) feed(8'(i));
      finish_build("t2");
      lookup(SubFwd, 8'h5A, 8'h5A, "t2_fwd_5a");
      random_lookups(8, "t2");
      lookup(SubFwd, 8'h5A, 8'h5A, "t2_fwd_5a_last");
      lookup_end();

      // 3: descending with repeated 0x10; lookups during FILL are ignored.
      do_start();
      @(posedge clk); #1;
      bus.sub_valid = 1'b1;
      bus.sub_data  = 8'h00;
      @(posedge clk); #1 bus.sub_valid = 1'b0;
      @(negedge clk);
      check("t3_fill_lookup_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("t3_fill_out_data_hold", {24'd0, bus.out_data}, 32'h5A);
      check("t3_fill_table_ready", {31'd0, bus.table_ready}, 32'd0);
      check("t3_fill_rej_cleared", {16'd0, bus.rej_count}, 32'd0);
      for (int v = 255; v >= 0; v--) begin
         feed(8'(v));
         if (v == 16) repeat (5) feed(8'h10);
      end
      finish_build("t3");
      check("t3_rej_count_5", {16'd0, bus.rej_count}, 32'd5);
      lookup(SubFwd, 8'h00, 8'hFF, "t3_fwd_00");
      lookup(SubInv, 8'hFF, 8'h00, "t3_inv_ff");
      random_lookups(20, "t3");
      lookup_end();

      // 4: affine stream; full round trip issued back-to-back.
      do_start();
      for (int i = 0; i < 256; i++) feed(8'((7 * i + 3) % 256));
      finish_build("t4");
      lookup(SubFwd, 8'h01, 8'h0A, "t4_fwd_01");
      lookup(SubInv, 8'h0A, 8'h01, "t4_inv_0a");
      for (int x = 0; x < 256; x++) lookup(SubFwd, 8'(x), model_fwd(x), "t4_fwd_all");
      for (int x = 0; x < 256; x++) lookup(SubInv, model_fwd(x), 8'(x), "t4_inv_of_fwd");
      lookup_end();

      // 5: restart mid-build with a colliding candidate, then a random build.
      do_start();
      for (int i = 0; i < 100; i++) feed(8'($urandom_range(0, 255)));
      @(posedge clk); #1;
      bus.start      = 1'b1;
      bus.cand_valid = 1'b1;
      bus.cand_data  = 8'hAB;
      @(posedge clk); #1;
      bus.start      = 1'b0;
      bus.cand_valid = 1'b0;
      model_reset();
      @(negedge clk);
      check("t5_restart_rej_count", {16'd0, bus.rej_count}, 32'd0);
      check("t5_restart_table_ready", {31'd0, bus.table_ready}, 32'd0);
      check("t5_restart_cand_ready", {31'd0, bus.cand_ready}, 32'd1);
      while (order.size() < 256) feed(8'($urandom_range(0, 255)));
      finish_build("t5");
      lookup(SubFwd, 8'h00, model_fwd(0), "t5_fwd_00");
      random_lookups(30, "t5");
      lookup_end();

      // 6a: reset during FILL.
      do_start();
      for (int i = 0; i < 50; i++) feed(8'($urandom_range(0, 255)));
      @(posedge clk); #3;
      rst_n          = 1'b0;
      bus.cand_valid = 1'b0;
      #1 check_reset_outputs("t6a");
      @(posedge clk); #1 rst_n = 1'b1;
      model_reset();

      // 6b: rebuild, then reset in the middle of a lookup burst.
      do_start();
      while (order.size() < 256) feed(8'($urandom_range(0, 255)));
      finish_build("t6b");
      random_lookups(10, "t6b");
      @(posedge clk); #3;
      rst_n         = 1'b0;
      bus.sub_valid = 1'b0;
      #1;
      check_reset_outputs("t6b");
      sb.delete();
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1 bus.sub_valid = 1'b1;
      @(posedge clk); #1 bus.sub_valid = 1'b0;
      @(negedge clk);
      check("t6b_post_reset_table_ready", {31'd0, bus.table_ready}, 32'd0);
      check("t6b_post_reset_out_valid", {31'd0, bus.out_valid}, 32'd0);

      // 6c: table usable again after a fresh build.
      do_start();
      for (int i = 0; i < 256; i++) feed(8'(255 - i));
      finish_build("t6c");
      random_lookups(12, "t6c");
      lookup_end();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
